// File: rtl/modpow2_table_gen_pkg.sv
// Shared types and defaults for the 2^i mod M table generator.
//   state_t     : generator FSM states
//   DEF_*       : default modulus width and table index range
//   bigmod      : reference a mod m over the default widths (not used in RTL)
package modpow2_table_gen_pkg;

    localparam int DEF_MOD_LEN   = 1024;
    localparam int DEF_FIRST_IDX = 1020;
    localparam int DEF_LAST_IDX  = 2047;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WARM = 2'd1,
        EMIT = 2'd2,
        FIN  = 2'd3
    } state_t;

    function automatic logic [DEF_MOD_LEN-1:0] bigmod(
        input logic [2*DEF_MOD_LEN-1:0] a,
        input logic [DEF_MOD_LEN-1:0]   m
    );
        logic [2*DEF_MOD_LEN-1:0] q;
        if (m == '0) begin
            q = '0;
        end else begin
            q = a % {{DEF_MOD_LEN{1'b0}}, m};
        end
        return q[DEF_MOD_LEN-1:0];
    endfunction

endpackage

// File: rtl/modpow2_table_gen_mod_double.sv
// Combinational modular doubling: o_y = (2 * i_r) mod i_m, valid for i_r < i_m.
//   i_r : operand, must already be reduced (i_r < i_m)
//   i_m : modulus
//   o_y : doubled and reduced result, always < i_m
module mod_double #(
    parameter int MOD_LEN = 1024
) (
    input  logic [MOD_LEN-1:0] i_r,
    input  logic [MOD_LEN-1:0] i_m,
    output logic [MOD_LEN-1:0] o_y
);

    // 2r < 2M, so a single conditional subtract fully reduces it. The extra
    // bit keeps 2r exact even for M = 2^MOD_LEN - 1.
    logic [MOD_LEN:0] w_t;
    logic [MOD_LEN:0] w_m_ext;
    logic             w_sub;

    assign w_t     = {i_r, 1'b0};
    assign w_m_ext = {1'b0, i_m};
    assign w_sub   = (w_t >= w_m_ext);
    assign o_y     = w_sub ? MOD_LEN'(w_t - w_m_ext) : w_t[MOD_LEN-1:0];

endmodule

// File: rtl/modpow2_table_gen.sv
// Streams the table 2^i mod M for i = FIRST_IDX..LAST_IDX, one modular
// doubling per cycle, over a valid/ready interface.
//   i_clk, i_reset     : clock, synchronous active-high reset
//   i_start, i_modulus : start request; modulus sampled when start is accepted
//   o_busy             : run in progress
//   o_out_valid/ready  : handshake for the current table entry
//   o_out_index/value  : exponent i and 2^i mod M
//   o_done             : one-cycle pulse after the last entry is accepted
//   o_err              : one-cycle pulse when start is accepted with M == 0
//
// state | meaning
// IDLE  | waiting for start
// WARM  | doubling up to FIRST_IDX, nothing emitted
// EMIT  | presenting entry idx, advance on handshake
// FIN   | done pulse, back to IDLE
module modpow2_table_gen
    import modpow2_table_gen_pkg::*;
#(
    parameter int MOD_LEN   = DEF_MOD_LEN,
    parameter int FIRST_IDX = DEF_FIRST_IDX,
    parameter int LAST_IDX  = DEF_LAST_IDX,
    parameter int IDX_W     = $clog2(LAST_IDX + 1)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [MOD_LEN-1:0] i_modulus,
    output logic               o_busy,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [IDX_W-1:0]   o_out_index,
    output logic [MOD_LEN-1:0] o_out_value,
    output logic               o_done,
    output logic               o_err
);

    state_t             r_state;
    logic [MOD_LEN-1:0] r_mod;
    logic [MOD_LEN-1:0] r_val;
    logic [IDX_W-1:0]   r_idx;
    logic               r_err;

    state_t             w_state_nxt;
    logic [MOD_LEN-1:0] w_mod_nxt;
    logic [MOD_LEN-1:0] w_val_nxt;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic               w_err_nxt;
    logic [MOD_LEN-1:0] w_dbl;
    logic [IDX_W-1:0]   w_idx_inc;

    mod_double #(
        .MOD_LEN (MOD_LEN)
    ) u_mod_double (
        .i_r (r_val),
        .i_m (r_mod),
        .o_y (w_dbl)
    );

    assign w_idx_inc = r_idx + IDX_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_mod_nxt   = r_mod;
        w_val_nxt   = r_val;
        w_idx_nxt   = r_idx;
        w_err_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    if (i_modulus == '0) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_mod_nxt   = i_modulus;
                        // 2^0 mod 1 is 0, otherwise 1
                        w_val_nxt   = (i_modulus == MOD_LEN'(1)) ? '0 : MOD_LEN'(1);
                        w_idx_nxt   = '0;
                        w_state_nxt = (FIRST_IDX == 0) ? EMIT : WARM;
                    end
                end
            end
            WARM: begin
                w_val_nxt = w_dbl;
                w_idx_nxt = w_idx_inc;
                if (w_idx_inc == IDX_W'(FIRST_IDX)) begin
                    w_state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (i_out_ready) begin
                    if (r_idx == IDX_W'(LAST_IDX)) begin
                        w_state_nxt = FIN;
                    end else begin
                        w_val_nxt = w_dbl;
                        w_idx_nxt = w_idx_inc;
                    end
                end
            end
            FIN: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_mod   <= '0;
            r_val   <= '0;
            r_idx   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mod   <= w_mod_nxt;
            r_val   <= w_val_nxt;
            r_idx   <= w_idx_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign o_busy      = (r_state != IDLE);
    assign o_out_valid = (r_state == EMIT);
    assign o_done      = (r_state == FIN);
    assign o_err       = r_err;
    assign o_out_index = r_idx;
    assign o_out_value = r_val;

endmodule

// File: tb/tb_modpow2_table_gen.sv
module tb_modpow2_table_gen;
    import modpow2_table_gen_pkg::*;

    logic clk;
    logic rst;

    // small instance: MOD_LEN=8, indices 4..12
    logic       s_start;
    logic [7:0] s_mod;
    logic       s_busy;
    logic       s_valid;
    logic       s_ready;
    logic [3:0] s_idx;
    logic [7:0] s_val;
    logic       s_done;
    logic       s_err;

    // default-parameter instance
    logic          b_start;
    logic [1023:0] b_mod;
    logic          b_busy;
    logic          b_valid;
    logic          b_ready;
    logic [10:0]   b_idx;
    logic [1023:0] b_val;
    logic          b_done;
    logic          b_err;

    int n_checks = 0;
    int n_errors = 0;

    modpow2_table_gen #(
        .MOD_LEN   (8),
        .FIRST_IDX (4),
        .LAST_IDX  (12)
    ) u_dut_small (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_start     (s_start),
        .i_modulus   (s_mod),
        .o_busy      (s_busy),
        .o_out_valid (s_valid),
        .i_out_ready (s_ready),
        .o_out_index (s_idx),
        .o_out_value (s_val),
        .o_done      (s_done),
        .o_err       (s_err)
    );

    modpow2_table_gen u_dut_big (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_start     (b_start),
        .i_modulus   (b_mod),
        .o_busy      (b_busy),
        .o_out_valid (b_valid),
        .i_out_ready (b_ready),
        .o_out_index (b_idx),
        .o_out_value (b_val),
        .o_done      (b_done),
        .o_err       (b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        string          name;
        logic [7:0]     m;
        bit             rnd;
        bit             repulse;
        logic [8:0][7:0] ev;
    } vec_t;

    vec_t tv[7];

    // results of the last small run
    int         acc_idx[$];
    logic [7:0] acc_val[$];
    int         first_cyc;
    int         done_gap;
    int         unstable;
    bit         timed_out;
    logic       busy_at1;

    // Called at a negedge. Starts the small DUT and collects accepted
    // entries until the done pulse, sampling at negedges.
    task automatic run_small(input logic [7:0] m, input bit rnd, input bit repulse);
        int         cyc;
        int         done_cyc;
        int         last_acc;
        bit         pv;
        bit         pr;
        logic [3:0] pi;
        logic [7:0] pval;
        acc_idx.delete();
        acc_val.delete();
        first_cyc = -1;
        done_cyc  = -1;
        last_acc  = -1;
        unstable  = 0;
        timed_out = 1'b0;
        busy_at1  = 1'b0;
        pv = 1'b0; pr = 1'b0; pi = '0; pval = '0;
        s_mod   = m;
        s_start = 1'b1;
        s_ready = 1'b0;
        cyc     = 0;
        while (done_cyc < 0) begin
            @(negedge clk);
            cyc++;
            s_start = 1'b0;
            if (repulse && s_valid && s_idx == 4'd6) begin
                s_start = 1'b1;
                s_mod   = 8'd7;
            end
            if (cyc == 1) busy_at1 = s_busy;
            if (s_done) done_cyc = cyc;
            if (s_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (pv && !pr && (s_idx != pi || s_val != pval)) unstable++;
                s_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (s_ready) begin
                    acc_idx.push_back(int'(s_idx));
                    acc_val.push_back(s_val);
                    last_acc = cyc;
                end
            end else begin
                s_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            pv = s_valid; pr = s_ready; pi = s_idx; pval = s_val;
            if (cyc > 200) begin
                timed_out = 1'b1;
                break;
            end
        end
        done_gap = done_cyc - last_acc;
        s_ready  = 1'b0;
        s_start  = 1'b0;
    endtask

    task automatic run_big(input logic [1023:0] m, input string nm);
        int            cyc;
        int            n;
        int            bad;
        int            done_cyc;
        int            last_acc;
        int            first_v;
        int            bad_i;
        logic [1023:0] expv;
        logic [1023:0] bad_act;
        logic [1023:0] bad_exp;
        cyc = 0; n = 0; bad = 0; done_cyc = -1; last_acc = -1; first_v = -1; bad_i = -1;
        bad_act = '0; bad_exp = '0;
        b_mod   = m;
        b_start = 1'b1;
        b_ready = 1'b1;
        while (done_cyc < 0 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            b_start = 1'b0;
            if (b_done) done_cyc = cyc;
            if (b_valid) begin
                if (first_v < 0) first_v = cyc;
                expv = bigmod(2048'(1) << (1020 + n), m);
                if (int'(b_idx) != 1020 + n || b_val != expv) begin
                    if (bad == 0) begin
                        bad_i   = 1020 + n;
                        bad_act = b_val;
                        bad_exp = expv;
                    end
                    bad++;
                end
                n++;
                last_acc = cyc;
            end
        end
        b_ready = 1'b0;
        chk({nm, "_entries"}, n, 1028);
        chk({nm, "_bad_entries"}, bad, 0);
        if (bad > 0)
            $display("  %s first differing index %0d got low %h expected low %h",
                     nm, bad_i, bad_act[191:0], bad_exp[191:0]);
        chk({nm, "_first_valid_cyc"}, first_v, 1021);
        chk({nm, "_done_gap"}, done_cyc - last_acc, 1);
    endtask

    initial begin
        int  cyc;
        bit  seen;

        tv[0].name = "m11_after_reset"; tv[0].m = 8'd11;  tv[0].rnd = 0; tv[0].repulse = 0;
        tv[0].ev = {8'd5, 8'd10, 8'd9, 8'd7, 8'd3, 8'd6, 8'd1, 8'd2, 8'd4};
        tv[1].name = "m13";             tv[1].m = 8'd13;  tv[1].rnd = 0; tv[1].repulse = 0;
        tv[1].ev = {8'd3, 8'd6, 8'd12, 8'd11, 8'd9, 8'd5, 8'd10, 8'd7, 8'd1};
        tv[2].name = "m13_rnd_ready";   tv[2].m = 8'd13;  tv[2].rnd = 1; tv[2].repulse = 0;
        tv[2].ev = tv[1].ev;
        tv[3].name = "m1";              tv[3].m = 8'd1;   tv[3].rnd = 0; tv[3].repulse = 0;
        tv[3].ev = '0;
        tv[4].name = "m13_restart";     tv[4].m = 8'd13;  tv[4].rnd = 0; tv[4].repulse = 1;
        tv[4].ev = tv[1].ev;
        tv[5].name = "m12_even";        tv[5].m = 8'd12;  tv[5].rnd = 1; tv[5].repulse = 0;
        tv[5].ev = {8'd4, 8'd8, 8'd4, 8'd8, 8'd4, 8'd8, 8'd4, 8'd8, 8'd4};
        tv[6].name = "m255_max";        tv[6].m = 8'd255; tv[6].rnd = 0; tv[6].repulse = 0;
        tv[6].ev = {8'd16, 8'd32, 8'd64, 8'd128, 8'd1, 8'd2, 8'd4, 8'd8, 8'd16};

        rst = 1'b1;
        s_start = 1'b0; s_mod = '0; s_ready = 1'b0;
        b_start = 1'b0; b_mod = '0; b_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy",  s_busy,  0);
        chk("reset_valid", s_valid, 0);
        chk("reset_done",  s_done,  0);
        chk("reset_err",   s_err,   0);
        chk("reset_index", s_idx,   0);
        chk("reset_value", s_val,   0);
        chk("reset_big_valid", b_valid, 0);
        rst = 1'b0;
        @(negedge clk);

        // M == 0: error pulse only
        s_mod = 8'd0; s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        chk("m0_err_pulse", s_err,   1);
        chk("m0_busy",      s_busy,  0);
        chk("m0_valid",     s_valid, 0);
        @(negedge clk);
        chk("m0_err_clear", s_err,   0);
        chk("m0_busy_2",    s_busy,  0);
        repeat (6) begin
            @(negedge clk);
            chk("m0_no_valid", s_valid, 0);
        end

        // reset while entry 7 is stalled
        s_mod = 8'd13; s_start = 1'b1; s_ready = 1'b1;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            s_start = 1'b0;
            if (s_valid && s_idx == 4'd7) begin
                seen    = 1'b1;
                s_ready = 1'b0;
            end
        end
        chk("stall_reached_idx7", seen, 1);
        repeat (2) begin
            @(negedge clk);
            chk("stall_hold_index", s_idx, 7);
            chk("stall_hold_value", s_val, 11);
            chk("stall_hold_valid", s_valid, 1);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy",  s_busy,  0);
        chk("abort_valid", s_valid, 0);
        chk("abort_done",  s_done,  0);
        chk("abort_err",   s_err,   0);
        chk("abort_index", s_idx,   0);
        chk("abort_value", s_val,   0);

        for (int v = 0; v < 7; v++) begin
            run_small(tv[v].m, tv[v].rnd, tv[v].repulse);
            chk({tv[v].name, "_timeout"}, timed_out, 0);
            chk({tv[v].name, "_count"}, acc_idx.size(), 9);
            for (int k = 0; k < 9; k++) begin
                if (k < acc_idx.size()) begin
                    chk($sformatf("%s_idx%0d", tv[v].name, k), acc_idx[k], 4 + k);
                    chk($sformatf("%s_val%0d", tv[v].name, k), acc_val[k], tv[v].ev[8-k]);
                end
            end
            chk({tv[v].name, "_first_valid_cyc"}, first_cyc, 5);
            chk({tv[v].name, "_done_gap"}, done_gap, 1);
            chk({tv[v].name, "_stable"}, unstable, 0);
            chk({tv[v].name, "_busy_after_start"}, busy_at1, 1);
            @(negedge clk);
            chk({tv[v].name, "_done_one_cycle"}, s_done, 0);
            chk({tv[v].name, "_idle_after"}, s_busy, 0);
        end

        run_big({1024{1'b1}}, "big_allones");
        @(negedge clk);
        run_big({16{64'h9E37_79B9_7F4A_7C15}}, "big_pattern");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/modpow2_table_gen.md
Name: modpow2_table_gen

Overview:
- Sequential generator of the reduction-constant table 2^i mod M, for i = FIRST_IDX..LAST_IDX.
- Hardware counterpart to the package function bigmod(2^i, M). Feeds the table-load port of the modular squarer family, so that table contents can be regenerated for any runtime modulus.
- Uses one modular doubling per cycle. Results stream out over a valid/ready interface.

Parameters:
- MOD_LEN, 1024: modulus and value width in bits.
- FIRST_IDX, 1020: first exponent emitted. Range 0..LAST_IDX.
- LAST_IDX, 2047: last exponent emitted.
- IDX_W, $clog2(LAST_IDX+1): width of the exponent index. Derived; do not override.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; modulus is sampled in the same cycle
- modulus  in  MOD_LEN  M; only sampled on an accepted start
- busy  out  1  high from the cycle after start is accepted until done
- out_valid  out  1  current entry is valid
- out_ready  in  1  consumer accepts the entry
- out_index  out  IDX_W  exponent i of the current entry
- out_value  out  MOD_LEN  2^i mod M
- done  out  1  one-cycle pulse after LAST_IDX is accepted
- err  out  1  one-cycle pulse when start is accepted with M == 0

Behaviour:
- Reset: state IDLE. busy, out_valid, done, err = 0; out_index = 0; out_value = 0.
- A reset asserted mid-operation aborts immediately. No done pulse.
- States: IDLE, WARM, EMIT, FIN.
- IDLE:
  - start with M == 0: err pulses next cycle; stay in IDLE.
  - start with M != 0: latch M; r <= (M == 1) ? 0 : 1; idx <= 0.
  - Next state is EMIT if FIRST_IDX == 0, else WARM.
  - start is ignored in every state except IDLE.
- WARM:
  - Each cycle: r <= dbl(r), idx <= idx + 1. Nothing is emitted.
  - Go to EMIT when idx + 1 == FIRST_IDX.
  - First out_valid is asserted exactly FIRST_IDX + 1 cycles after the start cycle.
- EMIT:
  - out_valid = 1, out_index = idx, out_value = r.
  - All three hold stable while out_ready = 0.
  - On out_valid & out_ready with idx != LAST_IDX: r <= dbl(r), idx <= idx + 1, out_valid stays high. Sustains one entry per cycle.
  - On out_valid & out_ready with idx == LAST_IDX: go to FIN; out_valid <= 0.
- FIN: done = 1 for one cycle; busy <= 0; return to IDLE. A start may be accepted in the following cycle.
- dbl(r), with r < M:
  - Form t = {r, 1'b0} (MOD_LEN+1 bits) and t - M.
  - Select t - M when t >= M, else t.
  - Result is < M. Single-cycle combinational.
- Boundary conditions:
  - M == 1: every value is 0.
  - M = 2^MOD_LEN - 1: the (MOD_LEN+1)-bit intermediate must not overflow.
  - Even M is legal.
  - Total entries = LAST_IDX - FIRST_IDX + 1.
  - Index never wraps: LAST_IDX < 2^IDX_W.

Decomposition:
- vdfpackage gains:
  - typedef enum for the states {IDLE, WARM, EMIT, FIN};
  - localparam defaults for the table range;
  - reuse of the existing bigmod for checking.
- One sub-module: mod_double. Parameter MOD_LEN; ports r, m -> y; purely combinational. Reused later by Montgomery setup logic.

Test Plan:
- MOD_LEN=8, FIRST_IDX=4, LAST_IDX=12, M=13, out_ready=1 -> (idx,val) = (4,3),(5,6),(6,12),(7,11),(8,9),(9,5),(10,10),(11,7),(12,1). First valid 5 cycles after start; done 1 cycle after the last accept.
- Same configuration, out_ready toggled randomly 50% -> identical sequence. Value and index held stable while stalled. No duplicates, no drops.
- M=1 -> 9 entries, all value 0. M=0 -> err pulse, busy stays 0, no out_valid.
- Reset asserted while idx=7 is stalled -> next cycle all outputs 0. A fresh start with M=11, FIRST_IDX=4 -> first entry (4,5).
- start re-pulsed during EMIT -> ignored; sequence and done unchanged.
- Default parameters, M = 1024-bit test modulus -> all 1028 entries match bigmod(2048'h1 << i, M) for i = 1020..2047; done after the 1028th accept.
